dmem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 18 +
 rtl/ls_align.sv | 57 +++++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store encodings and responder state type
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - byte-lane steering for stores and sign/zero extension for loads
module ls_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        align_err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        misaligned;
  logic        illegal;

  assign sel_byte = 8'(rword >> {addr_lo, 3'b000});
  assign sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    misaligned  = 1'b0;
    illegal     = 1'b0;
    wmask       = 4'b0000;
    wdata_lanes = '0;
    load_data   = '0;
    case (funct3)
      F3_B, F3_BU: begin
        illegal     = we && (funct3 == F3_BU);
        wmask       = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      end
      F3_H, F3_HU: begin
        illegal     = we && (funct3 == F3_HU);
        misaligned  = addr_lo[0];
        wmask       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      end
      F3_W: begin
        misaligned  = (addr_lo != 2'b00);
        wmask       = 4'b1111;
        wdata_lanes = wdata;
        load_data   = rword;
      end
      default: illegal = 1'b1;
    endcase
    align_err = misaligned | illegal;
    // Never hand out a write mask for a faulting access, so reusers cannot corrupt memory.
    if (align_err) wmask = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data-memory responder with wait states
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WS = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [3:0] CNT_INIT = (WS > 0) ? 4'(WS - 1) : 4'd0;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_wdata;

  // With zero wait states the response is computed straight from the incoming request.
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [2:0]  cur_funct3;
  logic [31:0] cur_wdata;
  logic        in_range;
  logic [AW-1:0] idx;
  logic [31:0] rword;
  logic [3:0]  wmask;
  logic [31:0] wdata_lanes;
  logic [31:0] load_data;
  logic        align_err;
  logic        access_err;
  logic        enter_resp;
  logic        mem_we;
  logic [31:0] next_rdata;

  assign cur_we     = (state == IDLE) ? req_we     : lat_we;
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;

  assign in_range = (cur_addr[31:2] < 30'(DEPTH_WORDS));
  assign idx      = cur_addr[AW+1:2];
  assign rword    = in_range ? mem[idx] : '0;

  ls_align u_align (
    .addr_lo     (cur_addr[1:0]),
    .funct3      (cur_funct3),
    .we          (cur_we),
    .wdata       (cur_wdata),
    .rword       (rword),
    .wmask       (wmask),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .align_err   (align_err)
  );

  assign access_err = align_err | ~in_range;
  assign enter_resp = ((state == IDLE) && req_valid && (WS == 0)) ||
                      ((state == WAIT) && (cnt == 4'd0));
  assign mem_we     = enter_resp && cur_we && !access_err && !rst;
  assign next_rdata = (access_err || cur_we) ? 32'd0 : load_data;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][b*8 +: 8] <= wdata_lanes[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_funct3 <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (enter_resp) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= next_rdata;
              rsp_err   <= access_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= next_rdata;
            rsp_err   <= access_err;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at several wait-state settings
module tb_dmem_responder;
  import mem_pkg::*;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic [3:0]  rstv;
  logic [3:0]  rv;
  logic [3:0]  rr;
  logic [3:0]  vld;
  logic [3:0]  err;
  logic [31:0] rd [4];
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rstv[0]), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(err[0]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rstv[1]), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(err[1]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .rst(rstv[2]), .req_valid(rv[2]), .req_ready(rr[2]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_rdata(rd[2]), .rsp_err(err[2]));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rstv[3]), .req_valid(rv[3]), .req_ready(rr[3]), .req_we(req_we),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(vld[3]), .rsp_rdata(rd[3]), .rsp_err(err[3]));

  function automatic int ws_of(input int i);
    case (i)
      0: return 1;
      1: return 0;
      2: return 15;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_rsp", 32'(i), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("rdata", rd[i], e.rd);
          check("err", {31'd0, err[i]}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic xact(input int i, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input bit noise);
    int   n;
    int   lat;
    int   rdy_hi;
    exp_t e;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; rv[i] = 1'b1;
    n = 0;
    while (!rr[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rr[i]) begin
      check("ready_timeout", 32'd0, 32'd1);
      rv[i] = 1'b0;
      return;
    end
    e.rd = exp_rd;
    e.err = exp_err;
    sbq.push_back(e);
    @(posedge clk);
    #1 rv[i] = 1'b0;
    lat = 0;
    rdy_hi = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rr[i]) rdy_hi++;
      if (vld[i]) break;
      if (noise) begin
        rv[i] = 1'b1;
        req_addr = $urandom;
        req_funct3 = 3'($urandom);
        req_we = 1'($urandom);
        req_wdata = $urandom;
      end
    end
    rv[i] = 1'b0;
    check("latency", 32'(lat), 32'(ws_of(i) + 1));
    check("ready_low_while_busy", 32'(rdy_hi), 32'd0);
    @(negedge clk);
    check("one_cycle_pulse", {30'd0, rr[i], vld[i]}, 32'b10);
  endtask

  task automatic bb(input int i);
    int last;
    int acc;
    int ncyc;
    exp_t e;
    last = -1;
    acc = 0;
    ncyc = 2 * (ws_of(i) + 2) + 1;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h5; rv[i] = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge clk);
      if (rr[i]) begin
        e.rd = 32'd0;
        e.err = 1'b0;
        sbq.push_back(e);
        if (last >= 0) check("b2b_gap", 32'(c - last), 32'(ws_of(i) + 2));
        last = c;
        acc++;
      end
    end
    @(posedge clk);
    #1 rv[i] = 1'b0;
    check("b2b_accepts", 32'(acc), 32'd3);
    repeat (ws_of(i) + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int vcount;
    rstv = 4'hF;
    rv = 4'h0;
    req_we = 1'b0; req_addr = '0; req_funct3 = F3_W; req_wdata = '0;
    repeat (3) @(negedge clk);
    rstv = 4'h0;
    @(negedge clk);
    check("rst_ready", {31'd0, rr[0]}, 32'd1);
    check("rst_valid", {31'd0, vld[0]}, 32'd0);
    check("rst_rdata", rd[0], 32'd0);
    check("rst_err", {31'd0, err[0]}, 32'd0);

    // basic word traffic and lane/extension cases, one wait state
    xact(0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(0, 0, F3_W,  32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(0, 1, F3_W,  32'h20, 32'h11223344, 32'h0, 0, 0);
    xact(0, 1, F3_B,  32'h21, 32'h00000080, 32'h0, 0, 0);
    xact(0, 0, F3_W,  32'h20, 32'h0, 32'h11228044, 0, 0);
    xact(0, 0, F3_B,  32'h21, 32'h0, 32'hFFFFFF80, 0, 0);
    xact(0, 0, F3_BU, 32'h21, 32'h0, 32'h00000080, 0, 0);
    xact(0, 0, F3_H,  32'h22, 32'h0, 32'h00001122, 0, 0);
    xact(0, 1, F3_H,  32'h22, 32'h0000F00D, 32'h0, 0, 0);
    xact(0, 0, F3_H,  32'h22, 32'h0, 32'hFFFFF00D, 0, 0);
    xact(0, 0, F3_HU, 32'h22, 32'h0, 32'h0000F00D, 0, 0);

    // error cases must not touch memory
    xact(0, 0, F3_W,   32'h22, 32'h0, 32'h0, 1, 0);
    xact(0, 1, F3_H,   32'h23, 32'h0000BEEF, 32'h0, 1, 0);
    xact(0, 0, F3_W,   32'h20, 32'h0, 32'hF00D8044, 0, 0);
    xact(0, 1, F3_W,   32'h100, 32'h12345678, 32'h0, 1, 0);
    xact(0, 1, F3_W,   32'h80000020, 32'hAAAAAAAA, 32'h0, 1, 0);
    xact(0, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 0);
    xact(0, 1, F3_BU,  32'h20, 32'h000000FF, 32'h0, 1, 0);
    xact(0, 0, F3_W,   32'h20, 32'h0, 32'hF00D8044, 0, 0);

    // latency extremes and held-valid throughput
    xact(1, 1, F3_W, 32'h0, 32'h0000A5A5, 32'h0, 0, 0);
    xact(1, 0, F3_W, 32'h0, 32'h0, 32'h0000A5A5, 0, 0);
    bb(1);
    xact(2, 1, F3_W, 32'h4, 32'h00000001, 32'h0, 0, 0);
    xact(2, 0, F3_W, 32'h4, 32'h0, 32'h00000001, 0, 0);
    bb(2);
    bb(0);

    // reset mid-operation drops a pending store
    xact(3, 1, F3_W, 32'h30, 32'h00000000, 32'h0, 0, 0);
    @(negedge clk);
    req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; rv[3] = 1'b1;
    @(posedge clk);
    #1 rv[3] = 1'b0;
    @(posedge clk);
    #2 rstv[3] = 1'b1;
    #1;
    check("rst_mid_ready", {31'd0, rr[3]}, 32'd1);
    check("rst_mid_valid", {31'd0, vld[3]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstv[3] = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (vld[3]) vcount++;
    end
    check("rst_no_rsp", 32'(vcount), 32'd0);
    xact(3, 0, F3_W, 32'h30, 32'h0, 32'h00000000, 0, 0);

    // requests presented while busy are ignored
    xact(3, 1, F3_W, 32'h44, 32'h12345678, 32'h0, 0, 1);
    xact(3, 0, F3_W, 32'h44, 32'h0, 32'h12345678, 0, 1);
    xact(3, 0, F3_B, 32'h47, 32'h0, 32'h00000012, 0, 1);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
